// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, status codes and the default datapath width.
package y86_pkg;
    localparam int DATA_W_DEF = 64;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;
endpackage

// File: rtl/data_ram.sv
// Word-addressed data array: synchronous write, asynchronous read, synchronous clear of every word.
module data_ram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 64,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Clear wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];
endmodule

// File: rtl/data_mem_stage.sv
// Y86-64 memory stage: access decode, address checking, multi-cycle latency counter and stall.
module data_mem_stage
    import y86_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        M_stat,
    input  logic [3:0]        M_icode,
    input  logic [63:0]       M_valE,
    input  logic [63:0]       M_valA,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    output logic [2:0]        m_stat,
    output logic [3:0]        m_icode,
    output logic [3:0]        m_dstE,
    output logic [3:0]        m_dstM,
    output logic [63:0]       m_valE,
    output logic [DATA_W-1:0] m_valM,
    output logic              m_stall
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(LATENCY - 1);
    localparam logic [60:0]   DEPTH_IDX = 61'(DEPTH);

    logic              is_rd, is_wr, rd_at_a;
    logic [63:0]       addr;
    logic              addr_err, legal, last;
    logic [CW-1:0]     cnt_d, cnt_q;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        is_rd   = 1'b0;
        is_wr   = 1'b0;
        rd_at_a = 1'b0;
        case (M_icode)
            I_MRMOVQ:        is_rd = 1'b1;
            I_RET, I_POPQ:   begin is_rd = 1'b1; rd_at_a = 1'b1; end
            I_RMMOVQ, I_CALL, I_PUSHQ: is_wr = 1'b1;
            default: ;
        endcase
    end

    assign addr     = rd_at_a ? M_valA : M_valE;
    assign addr_err = (is_rd | is_wr) && ((addr[2:0] != 3'b000) || (addr[63:3] >= DEPTH_IDX));
    assign legal    = (is_rd | is_wr) && (M_stat == SAOK) && !addr_err;
    assign last     = (cnt_q == CNT_LAST);
    assign m_stall  = legal && !last;

    // Count only while a legal access is waiting; anything else parks the counter at 0.
    always_comb begin
        cnt_d = '0;
        if (legal && !last) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    data_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .clr   (rst),
        .we    (legal && is_wr && last),
        .addr  (addr[AW+2:3]),
        .wdata (DATA_W'(M_valA)),
        .rdata (ram_rdata)
    );

    assign m_valM  = (legal && is_rd) ? ram_rdata : '0;
    assign m_stat  = ((M_stat == SAOK) && addr_err) ? SADR : M_stat;
    assign m_icode = M_icode;
    assign m_valE  = M_valE;
    assign m_dstE  = M_dstE;
    assign m_dstM  = M_dstM;
endmodule

// File: doc/data_mem_stage.md
DATA_MEM_STAGE -- requirements
Module: data_mem_stage

Interface
REQ-001 Parameter DEPTH, default 256, number of DATA_W-bit words in data memory; SHALL be a power of two.
REQ-002 Parameter DATA_W, default 64, data word width.
REQ-003 Parameter LATENCY, default 2, cycles per memory access; SHALL be >= 1.
REQ-004 Port clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port rst  in  1  reset; synchronous, active-high.
REQ-006 Ports M_stat  in  3, M_icode  in  4  status and icode from the M pipeline register.
REQ-007 Ports M_valE  in  64, M_valA  in  64  ALU result and operand A from the M register.
REQ-008 Ports M_dstE  in  4, M_dstM  in  4  destination register IDs.
REQ-009 Ports m_stat  out  3, m_icode  out  4, m_dstE  out  4, m_dstM  out  4, m_valE  out  64  forwarded to W and bypass logic.
REQ-010 Port m_valM  out  DATA_W  read data.
REQ-011 Port m_stall  out  1  high = access incomplete; the pipeline controller holds F/D/E/M and bubbles W.

Function
REQ-012 Reads SHALL use: mrmovq (5) at M_valE; ret (9) and popq (B) at M_valA.
REQ-013 Writes of M_valA SHALL use: rmmovq (4), call (8) and pushq (A) at M_valE.
REQ-014 Addresses are byte addresses; word index SHALL be addr[63:3].
REQ-015 An address error SHALL be raised for an access icode when addr[2:0] != 0 or index >= DEPTH.
REQ-016 legal = access icode AND M_stat == SAOK AND no address error.
REQ-017 m_stat SHALL be SADR when M_stat == SAOK and an address error is raised; otherwise M_stat.
REQ-018 m_icode, m_valE, m_dstE and m_dstM SHALL equal their M_* inputs combinationally, including during a stall.
REQ-019 Counter cnt (0..LATENCY-1): when legal and cnt < LATENCY-1, it SHALL increment each edge; otherwise it SHALL clear to 0.
REQ-020 m_stall SHALL be legal AND cnt < LATENCY-1, combinationally.
REQ-021 A legal access SHALL stall for exactly LATENCY-1 cycles; with LATENCY=1, m_stall is never asserted.
REQ-022 A write SHALL commit only at the edge ending the final cycle (legal, cnt == LATENCY-1); it SHALL never commit earlier or more than once.
REQ-023 m_valM SHALL be the addressed word (asynchronous array read) when a legal read is present; otherwise 0, with no latch.
REQ-024 An illegal access (error, or M_stat != SAOK) SHALL never stall and never write.
REQ-025 Back-to-back legal accesses SHALL each take a full LATENCY cycles.
REQ-026 A read in the cycle after a write to the same word SHALL return the new data.

Reset
REQ-027 While rst is high at an edge, the module SHALL clear cnt to 0 and zero all DEPTH words.
REQ-028 Reset SHALL override any pending write in that cycle.
REQ-029 During reset, m_stall SHALL follow REQ-020 with cnt = 0; m_valM SHALL follow REQ-023.
REQ-030 Reset mid-access SHALL abort the access and restart counting from 0 on the first non-reset cycle.

Structure
REQ-031 Package y86_pkg SHALL hold icode constants, the stat codes (SAOK=1, SHLT=2, SADR=3, SINS=4) and the default DATA_W.
REQ-032 Sub-module data_ram (DEPTH x DATA_W, synchronous write enable, asynchronous read, synchronous clear) SHALL hold the array.
REQ-033 data_mem_stage SHALL contain the decode, address check, counter and stall logic.

Verification
REQ-034 LATENCY=3: rmmovq (M_valE=0x10, M_valA=0xABCD), held while stalled -> m_stall = 1,1,0; word 2 = 0xABCD after the third edge only.
REQ-035 LATENCY=3: mrmovq at 0x10 after REQ-034 -> m_stall = 1,1,0; m_valM = 0xABCD; m_stat = 1.
REQ-036 mrmovq at 0x13, then at 0x800 with DEPTH=256 -> m_stat = 3, m_stall = 0, m_valM = 0; no write.
REQ-037 pushq with M_stat=4 at 0x20 -> m_stat = 4, m_stall = 0; word 4 unchanged.
REQ-038 LATENCY=3: rst asserted in the second cycle of rmmovq at 0x18 -> word 3 = 0; the access restarts with a full 2-cycle stall after rst drops.
REQ-039 LATENCY=1: alternating pushq/popq at 0x30 (data 0x55) -> m_stall = 0 throughout; popq returns 0x55.
